// File: rtl/issue_queue_pkg.sv
// Shared micro-op bundle and issue-queue widths.
// Imported by issue_queue and tb_issue_queue.
package issue_queue_pkg;

    localparam int DISPATCH_WIDTH = 4;
    localparam int ISSUE_WIDTH    = 2;
    localparam int WAKEUP_WIDTH   = 4;
    localparam int PREG_W         = 6;

    typedef enum logic [1:0] {
        IQ_INT = 2'd0,
        IQ_MEM = 2'd1,
        IQ_FP  = 2'd2
    } iq_code_e;

    typedef struct packed {
        logic              valid;
        iq_code_e          iq_code;
        logic [PREG_W-1:0] rs1_preg;
        logic [PREG_W-1:0] rs2_preg;
        logic              rs1_ready;
        logic              rs2_ready;
    } micro_op_t;

endpackage

// File: rtl/iq_select.sv
// Lowest-index multi-grant picker: grant g is one-hot on the
// g-th lowest set request bit, or zero when fewer requests exist.
module iq_select #(
    parameter int N = 16,
    parameter int G = 2
) (
    input  logic [N-1:0]        req,
    output logic [G-1:0][N-1:0] gnt
);

    logic [N-1:0] avail;
    logic         hit;

    always_comb begin
        gnt   = '0;
        avail = req;
        hit   = 1'b0;
        for (int g = 0; g < G; g++) begin
            hit = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!hit && avail[i]) begin
                    gnt[g][i] = 1'b1;
                    hit       = 1'b1;
                end
            end
            avail = avail & ~gnt[g];
        end
    end

endmodule

// File: rtl/issue_queue.sv
// Non-collapsing issue queue with wakeup and registered issue ports.
// Optional IQ_PERF_COUNTERS_EN adds stall_cycles and issued_total.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int IQ_SIZE = 16
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   flush,
    input  micro_op_t [DISPATCH_WIDTH-1:0]         uop_in,
    output logic                                   ready_out,
    output logic [$clog2(IQ_SIZE):0]               free_count,
    input  logic [WAKEUP_WIDTH-1:0]                wakeup_valid,
    input  logic [WAKEUP_WIDTH-1:0][PREG_W-1:0]    wakeup_preg,
    input  logic [ISSUE_WIDTH-1:0]                 issue_ready,
    output micro_op_t [ISSUE_WIDTH-1:0]            uop_out
`ifdef IQ_PERF_COUNTERS_EN
    ,
    output logic [31:0]                            stall_cycles,
    output logic [31:0]                            issued_total
`endif
);

    localparam int CNT_W = $clog2(IQ_SIZE) + 1;

    micro_op_t [IQ_SIZE-1:0]                slot_q;
    micro_op_t [IQ_SIZE-1:0]                slot_d;
    micro_op_t [ISSUE_WIDTH-1:0]            out_d;
    logic [CNT_W-1:0]                       count_d;
    logic [IQ_SIZE-1:0]                     free_vec;
    logic [IQ_SIZE-1:0]                     elig_vec;
    logic [DISPATCH_WIDTH-1:0][IQ_SIZE-1:0] alloc_gnt;
    logic [ISSUE_WIDTH-1:0][IQ_SIZE-1:0]    sel_gnt;
    logic [IQ_SIZE-1:0]                     pick;
    logic                                   lane_any;
    int                                     rank;
    int                                     n_issue;
    int                                     n_alloc;

    function automatic logic woken(input logic [PREG_W-1:0] tag);
        woken = (tag == '0);
        for (int w = 0; w < WAKEUP_WIDTH; w++) begin
            if (wakeup_valid[w] && wakeup_preg[w] == tag) woken = 1'b1;
        end
    endfunction

    assign ready_out = free_count >= CNT_W'(DISPATCH_WIDTH);

    always_comb begin
        free_vec = '0;
        elig_vec = '0;
        lane_any = 1'b0;
        for (int i = 0; i < IQ_SIZE; i++) begin
            free_vec[i] = !slot_q[i].valid;
            elig_vec[i] = slot_q[i].valid && slot_q[i].rs1_ready
                          && slot_q[i].rs2_ready;
        end
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            lane_any = lane_any | uop_in[k].valid;
        end
    end

    iq_select #(.N(IQ_SIZE), .G(DISPATCH_WIDTH)) u_alloc (
        .req (free_vec),
        .gnt (alloc_gnt)
    );

    iq_select #(.N(IQ_SIZE), .G(ISSUE_WIDTH)) u_pick (
        .req (elig_vec),
        .gnt (sel_gnt)
    );

    always_comb begin
        slot_d  = slot_q;
        out_d   = '0;
        pick    = '0;
        rank    = 0;
        n_issue = 0;
        n_alloc = 0;
        for (int i = 0; i < IQ_SIZE; i++) begin
            slot_d[i].rs1_ready = slot_q[i].rs1_ready | woken(slot_q[i].rs1_preg);
            slot_d[i].rs2_ready = slot_q[i].rs2_ready | woken(slot_q[i].rs2_preg);
        end
        // Ready ports consume the ordered grants in port order.
        for (int p = 0; p < ISSUE_WIDTH; p++) begin
            if (issue_ready[p]) begin
                pick = '0;
                for (int g = 0; g < ISSUE_WIDTH; g++) begin
                    if (g == rank) pick = sel_gnt[g];
                end
                for (int i = 0; i < IQ_SIZE; i++) begin
                    if (pick[i]) begin
                        out_d[p]        = slot_q[i];
                        slot_d[i].valid = 1'b0;
                    end
                end
                if (|pick) n_issue++;
                rank++;
            end
        end
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            if (uop_in[k].valid && ready_out) begin
                for (int i = 0; i < IQ_SIZE; i++) begin
                    if (alloc_gnt[k][i]) begin
                        slot_d[i]           = uop_in[k];
                        slot_d[i].rs1_ready = uop_in[k].rs1_ready
                                              | woken(uop_in[k].rs1_preg);
                        slot_d[i].rs2_ready = uop_in[k].rs2_ready
                                              | woken(uop_in[k].rs2_preg);
                    end
                end
                n_alloc++;
            end
        end
        count_d = CNT_W'(int'(free_count) - n_alloc + n_issue);
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            slot_q     <= '0;
            uop_out    <= '0;
            free_count <= CNT_W'(IQ_SIZE);
        end else begin
            slot_q     <= slot_d;
            uop_out    <= out_d;
            free_count <= count_d;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (!reset && !flush && !ready_out) begin
            assert (!lane_any)
            else $warning("issue_queue: dispatch while not ready, lane dropped");
        end
    end
`endif

`ifdef IQ_PERF_COUNTERS_EN
    logic [32:0] issued_sum;

    always_comb begin
        issued_sum = {1'b0, issued_total};
        for (int p = 0; p < ISSUE_WIDTH; p++) begin
            issued_sum = issued_sum + 33'(uop_out[p].valid);
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            stall_cycles <= '0;
            issued_total <= '0;
        end else begin
            if (!ready_out && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
            issued_total <= issued_sum[32] ? '1 : issued_sum[31:0];
        end
    end
`endif

endmodule
